// File: rtl/addsub_pkg.sv
// Shared types and golden model for the addsub32 response checker.
// Holds the state encoding, the {ans, cout, v} result bundle and the reference add/subtract.
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CHECK
  } state_t;

  typedef struct packed {
    logic [ADDSUB_WIDTH-1:0] ans;
    logic                    cout;
    logic                    v;
  } result_t;

  // Subtraction is A + ~B + 1, so carry-out means "no borrow".
  function automatic result_t addsub_ref(input logic [ADDSUB_WIDTH-1:0] a,
                                         input logic [ADDSUB_WIDTH-1:0] b,
                                         input logic                    sub);
    logic [ADDSUB_WIDTH-1:0] bx;
    logic [ADDSUB_WIDTH:0]   sum;
    result_t                 r;
    bx     = sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bx} + {{ADDSUB_WIDTH{1'b0}}, sub};
    r.ans  = sum[ADDSUB_WIDTH-1:0];
    r.cout = sum[ADDSUB_WIDTH];
    r.v    = (a[ADDSUB_WIDTH-1] == bx[ADDSUB_WIDTH-1]) &&
             (r.ans[ADDSUB_WIDTH-1] != a[ADDSUB_WIDTH-1]);
    return r;
  endfunction

endpackage

// File: rtl/addsub_stats.sv
// Pass/error statistics for the addsub checker: saturating counters, worst-case settle
// tracking and a sticky capture of the operands of the first failing check.
module addsub_stats
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             update,
  input  logic             fail,
  input  logic [CNT_W-1:0] settle,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] max_settle,
  output logic             ferr_valid,
  output logic [WIDTH-1:0] ferr_a,
  output logic [WIDTH-1:0] ferr_b,
  output logic             ferr_sub
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // A clear coinciding with an update wins, so that check is simply not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_count <= '0;
      err_count  <= '0;
      max_settle <= '0;
      ferr_valid <= 1'b0;
      ferr_a     <= '0;
      ferr_b     <= '0;
      ferr_sub   <= 1'b0;
    end else if (clr) begin
      test_count <= '0;
      err_count  <= '0;
      max_settle <= '0;
      ferr_valid <= 1'b0;
      ferr_a     <= '0;
      ferr_b     <= '0;
      ferr_sub   <= 1'b0;
    end else if (update) begin
      test_count <= sat_inc(test_count);
      if (settle > max_settle) begin
        max_settle <= settle;
      end
      if (fail) begin
        err_count <= sat_inc(err_count);
        if (!ferr_valid) begin
          ferr_valid <= 1'b1;
          ferr_a     <= a;
          ferr_b     <= b;
          ferr_sub   <= sub;
        end
      end
    end
  end

endmodule

// File: rtl/addsub_checker.sv
// Self-test companion for addsub32: drives registered operands, watches the result settle
// over SETTLE_N edges, and checks the final sample against the golden model.
module addsub_checker
  import addsub_pkg::*;
#(
  parameter int WIDTH    = ADDSUB_WIDTH,
  parameter int SETTLE_N = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_sub,
  input  logic [WIDTH-1:0] dut_ans,
  input  logic             dut_cout,
  input  logic             dut_v,
  input  logic             stats_clr,
  output logic             done,
  output logic             pass,
  output logic             unstable,
  output logic [CNT_W-1:0] settle,
  output logic [CNT_W-1:0] max_settle,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] err_count,
  output logic             ferr_valid,
  output logic [WIDTH-1:0] ferr_a,
  output logic [WIDTH-1:0] ferr_b,
  output logic             ferr_sub
);

  localparam int            KW     = $clog2(SETTLE_N + 1);
  localparam logic [KW-1:0] K_LAST = KW'(SETTLE_N);

  state_t        state, state_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [KW-1:0] last_chg, chg_idx;
  result_t       prev, expected, sample;
  logic          accept, final_sample, sample_chg;

  assign sample = {dut_ans, dut_cout, dut_v};

  // Next state plus the per-edge change tracking; chg_idx is last_chg including this edge.
  always_comb begin
    state_nxt    = state;
    op_ready     = 1'b0;
    accept       = 1'b0;
    final_sample = 1'b0;
    k_nxt        = k + 1'b1;
    sample_chg   = (sample != prev);
    chg_idx      = sample_chg ? k_nxt : last_chg;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        final_sample = (k_nxt == K_LAST);
        if (final_sample) begin
          state_nxt = CHECK;
        end
      end
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_a    <= '0;
      dut_b    <= '0;
      dut_sub  <= 1'b0;
      expected <= '0;
      prev     <= '0;
      k        <= '0;
      last_chg <= '0;
    end else if (accept) begin
      dut_a    <= op_a;
      dut_b    <= op_b;
      dut_sub  <= op_sub;
      expected <= addsub_ref(op_a, op_b, op_sub);
      prev     <= sample;
      k        <= '0;
      last_chg <= '0;
    end else if (state == WAIT) begin
      k        <= k_nxt;
      last_chg <= chg_idx;
      prev     <= sample;
    end
  end

  // The verdict is formed on the final sampling edge so done, pass and settle align in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      pass     <= 1'b0;
      unstable <= 1'b0;
      settle   <= '0;
    end else begin
      done <= final_sample;
      if (final_sample) begin
        pass     <= (sample == expected) && (chg_idx != K_LAST);
        unstable <= (chg_idx == K_LAST);
        settle   <= CNT_W'(chg_idx);
      end
    end
  end

  addsub_stats #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .clr       (stats_clr),
    .update    (state == CHECK),
    .fail      (~pass),
    .settle    (settle),
    .a         (dut_a),
    .b         (dut_b),
    .sub       (dut_sub),
    .test_count(test_count),
    .err_count (err_count),
    .max_settle(max_settle),
    .ferr_valid(ferr_valid),
    .ferr_a    (ferr_a),
    .ferr_b    (ferr_b),
    .ferr_sub  (ferr_sub)
  );

endmodule
